dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port between the execute unit (CPU) and a secondary
//  requester (DMA/debug loader). The CPU has priority. A starvation counter forces a
//  one-cycle DMA slot after STARVE_LIMIT consecutive losing cycles, and it raises
//  cpu_stall so fetch/decode hold the current instruction. Sits between execute and data RAM.
// PARAMETERS
//  ADDR_W        12  data-memory address width
//  DATA_W        8   data width
//  STARVE_LIMIT  4   max consecutive cycles dma_req may lose before a forced DMA slot (>=1)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       asynchronous, active-high reset
//  cpu_mem_en     in   1       CPU access request (from execute d_mem_en)
//  cpu_mem_rd     in   1       CPU read
//  cpu_mem_wr     in   1       CPU write
//  cpu_mem_addr   in   ADDR_W  CPU address
//  cpu_mem_wdata  in   DATA_W  CPU write data
//  cpu_mem_rdata  out  DATA_W  CPU read data (same cycle)
//  cpu_stall      out  1       CPU access dropped this cycle; pipeline must hold and reissue
//  dma_req        in   1       DMA request; held with stable fields until dma_gnt
//  dma_we         in   1       1=write, 0=read
//  dma_addr       in   ADDR_W  DMA address
//  dma_wdata      in   DATA_W  DMA write data
//  dma_gnt        out  1       DMA access is on the memory port this cycle
//  dma_rdata      out  DATA_W  registered DMA read data
//  dma_rvld       out  1       dma_rdata valid (1-cycle pulse, cycle after a read grant)
//  mem_en/mem_rd/mem_wr out 1  memory port controls
//  mem_addr       out  ADDR_W  memory address
//  mem_wdata      out  DATA_W  memory write data
//  mem_rdata      in   DATA_W  memory read data, combinational (valid the same cycle as mem_en&mem_rd)
// BEHAVIOUR
//  States: ARB_CPU (normal), ARB_FORCE (one forced DMA cycle). Reset state is ARB_CPU.
//  Starvation counter starve_cnt uses $clog2(STARVE_LIMIT+1) bits.
//  - ARB_CPU: if cpu_mem_en=1, the CPU owns the port. If cpu_mem_en=0 and dma_req=1, the DMA owns it.
//    If both are idle, the mem_* outputs are 0.
//  - starve_cnt increments (saturating at STARVE_LIMIT) on every cycle with dma_req=1 and dma_gnt=0.
//    It clears on dma_gnt or when dma_req=0.
//  - Next state is ARB_FORCE when starve_cnt==STARVE_LIMIT-1 and this cycle increments it.
//    Otherwise the next state is ARB_CPU.
//  - ARB_FORCE: the DMA owns the port unconditionally. cpu_stall=cpu_mem_en. The CPU access is
//    not issued, and cpu_mem_rdata=0. Next state is ARB_CPU. If dma_req deasserts illegally,
//    the port is idle and no gnt is given.
//  - Ownership is combinational. mem_* mirror the owner: the CPU maps en/rd/wr directly.
//    For DMA, mem_en=1, mem_wr=dma_we, mem_rd=~dma_we. dma_gnt=1 exactly in DMA-owned cycles.
//  - cpu_mem_rdata=mem_rdata when the CPU owns the port and cpu_mem_rd=1, else 0.
//  - DMA read: dma_rdata<=mem_rdata at the grant edge, and dma_rvld=1 in the next cycle only.
//    dma_rdata holds its value until the next DMA read grant.
//  - Back-to-back DMA grants are legal. An rvld for grant N may coincide with grant N+1.
//  - Latency: an unopposed DMA access has 0 wait cycles. Worst case is STARVE_LIMIT wait cycles.
//  - Asynchronous reset (also mid-operation) clears the following immediately:
//    state=ARB_CPU, starve_cnt=0, dma_rdata=0, dma_rvld=0.
//    While reset=1, all mem_* outputs, dma_gnt, cpu_stall and cpu_mem_rdata are forced to 0.
//    A DMA read granted in the reset cycle produces no rvld.
// TESTING
//  1 Reset: reset=1 with cpu_mem_en=1 and dma_req=1 -> all outputs 0 immediately (no clock edge).
//    After release, state=ARB_CPU and starve_cnt=0.
//  2 CPU read: cpu_mem_en=1, cpu_mem_rd=1, cpu_mem_addr=0x123, mem_rdata=0x5A -> mem_addr=0x123
//    same cycle, cpu_mem_rdata=0x5A, cpu_stall=0, dma_gnt=0.
//  3 DMA idle-slot write then read: dma_we=1, addr=0x0A5, wdata=0x3C -> dma_gnt and mem_wr same
//    cycle. Then a read of 0x0A5 with mem_rdata=0x3C -> dma_rvld=1 and dma_rdata=0x3C next cycle.
//  4 Starvation: cpu_mem_en=1 continuously, dma_req held from cycle 0 -> dma_gnt=0 in cycles 0-3.
//    Cycle 4: dma_gnt=1 and cpu_stall=1. Cycle 5: CPU owns the port and starve_cnt=0.
//  5 Back-to-back DMA reads to 0x010/0x011 with the CPU idle -> gnt in cycles 0 and 1.
//    dma_rvld in cycles 1 and 2 with the matching data.
//  6 Reset asserted during ARB_FORCE with a DMA read granted -> no dma_rvld.
//    After release, the held dma_req is re-granted in the first CPU-idle cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the CPU has priority over the DMA/debug requester,
// and a starvation counter forces a single DMA slot once the DMA has lost
// STARVE_LIMIT cycles in a row.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mem_en,
    input  logic              cpu_mem_rd,
    input  logic              cpu_mem_wr,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [DATA_W-1:0] cpu_mem_wdata,
    output logic [DATA_W-1:0] cpu_mem_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvld,
    output logic              mem_en,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CntMax    = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CntPreMax = CW'(STARVE_LIMIT - 1);

    typedef enum logic [0:0] {ArbCpu, ArbForce} arb_state_e;

    arb_state_e    state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          cpu_own, dma_own, starve_inc;

    // Decide ownership this cycle; everything is gated off while reset is high.
    always_comb begin
        cpu_own   = 1'b0;
        dma_own   = 1'b0;
        cpu_stall = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ArbCpu: begin
                    if (cpu_mem_en)   cpu_own = 1'b1;
                    else if (dma_req) dma_own = 1'b1;
                end
                ArbForce: begin
                    // A dropped dma_req here leaves the port idle rather than handing it back.
                    dma_own   = dma_req;
                    cpu_stall = cpu_mem_en;
                end
            endcase
        end
    end

    // Drive the memory port from whichever side owns it.
    always_comb begin
        mem_en        = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        cpu_mem_rdata = '0;
        dma_gnt       = dma_own;
        if (cpu_own) begin
            mem_en    = 1'b1;
            mem_rd    = cpu_mem_rd;
            mem_wr    = cpu_mem_wr;
            mem_addr  = cpu_mem_addr;
            mem_wdata = cpu_mem_wdata;
            if (cpu_mem_rd) cpu_mem_rdata = mem_rdata;
        end else if (dma_own) begin
            mem_en    = 1'b1;
            mem_rd    = ~dma_we;
            mem_wr    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    // Starvation counter and next arbitration state.
    always_comb begin
        starve_inc   = dma_req & ~dma_gnt;
        starve_cnt_d = '0;
        state_d      = ArbCpu;
        if (starve_inc) begin
            starve_cnt_d = (starve_cnt_q == CntMax) ? CntMax : starve_cnt_q + CW'(1);
            if (starve_cnt_q == CntPreMax) state_d = ArbForce;
        end
    end

    // Arbitration state, starvation count and registered DMA read return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ArbCpu;
            starve_cnt_q <= '0;
            dma_rdata    <= '0;
            dma_rvld     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dma_rvld     <= dma_gnt & ~dma_we;
            if (dma_gnt && !dma_we) dma_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_en, cpu_mem_rd, cpu_mem_wr;
    logic [11:0] cpu_mem_addr;
    logic [7:0]  cpu_mem_wdata, cpu_mem_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [11:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic        dma_gnt, dma_rvld;
    logic        mem_en, mem_rd, mem_wr;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    dmem_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_en(cpu_mem_en), .cpu_mem_rd(cpu_mem_rd), .cpu_mem_wr(cpu_mem_wr),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_rdata(cpu_mem_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvld(dma_rvld),
        .mem_en(mem_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_mem_en = 0; cpu_mem_rd = 0; cpu_mem_wr = 0; cpu_mem_addr = '0; cpu_mem_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; mem_rdata = '0;
    endtask

    initial begin
        // 1: reset forces outputs low without any clock edge
        idle_inputs();
        reset = 1; cpu_mem_en = 1; cpu_mem_rd = 1; cpu_mem_addr = 12'h456;
        dma_req = 1; mem_rdata = 8'hEE;
        #2;
        check_eq("rst_mem_en", 32'(mem_en), 0);
        check_eq("rst_mem_addr", 32'(mem_addr), 0);
        check_eq("rst_gnt", 32'(dma_gnt), 0);
        check_eq("rst_stall", 32'(cpu_stall), 0);
        check_eq("rst_cpu_rdata", 32'(cpu_mem_rdata), 0);
        check_eq("rst_rvld", 32'(dma_rvld), 0);
        check_eq("rst_rdata", 32'(dma_rdata), 0);
        tick(); tick();
        idle_inputs();
        reset = 0;
        #1;
        check_eq("rel_state", 32'(dut.state_q), 0);
        check_eq("rel_cnt", 32'(dut.starve_cnt_q), 0);

        // 2: CPU read
        tick();
        cpu_mem_en = 1; cpu_mem_rd = 1; cpu_mem_addr = 12'h123; mem_rdata = 8'h5A;
        #1;
        check_eq("cpu_mem_addr", 32'(mem_addr), 32'h123);
        check_eq("cpu_mem_rd", 32'(mem_rd), 1);
        check_eq("cpu_rdata", 32'(cpu_mem_rdata), 32'h5A);
        check_eq("cpu_stall", 32'(cpu_stall), 0);
        check_eq("cpu_gnt", 32'(dma_gnt), 0);

        // 3: DMA write in an idle slot, then read back
        tick();
        idle_inputs();
        dma_req = 1; dma_we = 1; dma_addr = 12'h0A5; dma_wdata = 8'h3C;
        #1;
        check_eq("dw_gnt", 32'(dma_gnt), 1);
        check_eq("dw_mem_wr", 32'(mem_wr), 1);
        check_eq("dw_mem_rd", 32'(mem_rd), 0);
        check_eq("dw_addr", 32'(mem_addr), 32'h0A5);
        check_eq("dw_wdata", 32'(mem_wdata), 32'h3C);
        tick();
        dma_we = 0; mem_rdata = 8'h3C;
        #1;
        check_eq("dr_gnt", 32'(dma_gnt), 1);
        check_eq("dr_mem_rd", 32'(mem_rd), 1);
        check_eq("dw_no_rvld", 32'(dma_rvld), 0);
        tick();
        dma_req = 0; mem_rdata = 8'h00;
        #1;
        check_eq("dr_rvld", 32'(dma_rvld), 1);
        check_eq("dr_rdata", 32'(dma_rdata), 32'h3C);
        tick();
        check_eq("dr_rvld_pulse", 32'(dma_rvld), 0);
        check_eq("dr_rdata_hold", 32'(dma_rdata), 32'h3C);

        // 4: starvation under continuous CPU traffic; forced slot in cycle 4
        idle_inputs();
        cpu_mem_en = 1; cpu_mem_rd = 1; cpu_mem_addr = 12'h300;
        dma_req = 1; dma_we = 0; dma_addr = 12'h200; mem_rdata = 8'h77;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) dma_req = 0;
            #1;
            check_eq($sformatf("st_gnt_c%0d", c), 32'(dma_gnt), (c == 4) ? 1 : 0);
            check_eq($sformatf("st_stall_c%0d", c), 32'(cpu_stall), (c == 4) ? 1 : 0);
            check_eq($sformatf("st_addr_c%0d", c), 32'(mem_addr),
                     (c == 4) ? 32'h200 : 32'h300);
            check_eq($sformatf("st_cpu_rdata_c%0d", c), 32'(cpu_mem_rdata),
                     (c == 4) ? 0 : 32'h77);
            if (c == 5) begin
                check_eq("st_cnt_c5", 32'(dut.starve_cnt_q), 0);
                check_eq("st_rvld_c5", 32'(dma_rvld), 1);
                check_eq("st_rdata_c5", 32'(dma_rdata), 32'h77);
            end
            tick();
        end

        // 5: back-to-back DMA reads with CPU idle
        idle_inputs();
        dma_req = 1; dma_addr = 12'h010; mem_rdata = 8'h11;
        #1;
        check_eq("bb_gnt0", 32'(dma_gnt), 1);
        check_eq("bb_addr0", 32'(mem_addr), 32'h010);
        tick();
        dma_addr = 12'h011; mem_rdata = 8'h22;
        #1;
        check_eq("bb_gnt1", 32'(dma_gnt), 1);
        check_eq("bb_rvld1", 32'(dma_rvld), 1);
        check_eq("bb_rdata1", 32'(dma_rdata), 32'h11);
        tick();
        dma_req = 0; mem_rdata = 8'h00;
        #1;
        check_eq("bb_gnt2", 32'(dma_gnt), 0);
        check_eq("bb_rvld2", 32'(dma_rvld), 1);
        check_eq("bb_rdata2", 32'(dma_rdata), 32'h22);
        tick();
        check_eq("bb_rvld3", 32'(dma_rvld), 0);

        // 6: reset during a forced DMA read slot
        cpu_mem_en = 1; cpu_mem_rd = 1; cpu_mem_addr = 12'h300;
        dma_req = 1; dma_we = 0; dma_addr = 12'h0F0; mem_rdata = 8'h99;
        for (int c = 0; c < 4; c++) tick();
        #1;
        check_eq("rf_gnt", 32'(dma_gnt), 1);
        check_eq("rf_state", 32'(dut.state_q), 1);
        reset = 1;
        #1;
        check_eq("rf_gnt_rst", 32'(dma_gnt), 0);
        check_eq("rf_state_rst", 32'(dut.state_q), 0);
        check_eq("rf_mem_en_rst", 32'(mem_en), 0);
        tick();
        reset = 0;
        #1;
        check_eq("rf_no_rvld", 32'(dma_rvld), 0);
        check_eq("rf_cpu_owns", 32'(dma_gnt), 0);
        check_eq("rf_cpu_addr", 32'(mem_addr), 32'h300);
        tick();
        cpu_mem_en = 0; cpu_mem_rd = 0;
        #1;
        check_eq("rf_regrant", 32'(dma_gnt), 1);
        check_eq("rf_regrant_addr", 32'(mem_addr), 32'h0F0);
        tick();
        dma_req = 0;
        #1;
        check_eq("rf_rvld", 32'(dma_rvld), 1);
        check_eq("rf_rdata", 32'(dma_rdata), 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
